// File: rtl/nnrv_pkg.sv
// Shared sizing constants for the NNRV core and its writeback stage.
// Also holds the single definition of the register-commit condition.
package nnrv_pkg;
   localparam int XLEN_DEF   = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int CNT_W      = 64;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   // Only a valid retirement that targets a real register commits.
   function automatic logic commit_en(input logic valid, input logic rd_en, input reg_addr_t rd);
      return valid & rd_en & (rd != '0);
   endfunction
endpackage

// File: rtl/nnrv_regfile.sv
// x1..x31 storage with one write port and two write-through read ports.
// x0 has no flops; it reads as a tied-off zero entry.
import nnrv_pkg::*;

module nnrv_regfile #(
   parameter int XLEN = XLEN_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_we,
   input  logic [REG_ADDR_W-1:0] i_wa,
   input  logic [XLEN-1:0]       i_wd,
   input  logic [REG_ADDR_W-1:0] i_rs1,
   input  logic [REG_ADDR_W-1:0] i_rs2,
   output logic [XLEN-1:0]       o_rs1_reg,
   output logic [XLEN-1:0]       o_rs2_reg
);
   logic [XLEN-1:0] regs [NUM_REGS];
   logic            we_eff;
   logic            byp;

   assign we_eff  = i_we & (i_wa != '0);
   assign regs[0] = '0;

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
      logic [XLEN-1:0] q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n)
            q <= '0;
         else if (we_eff && i_wa == REG_ADDR_W'(g))
            q <= i_wd;
      end
      assign regs[g] = q;
   end

   // Bypass is gated by reset so every read is zero while held in reset.
   assign byp = we_eff & i_rst_n;

   always_comb begin
      o_rs1_reg = regs[i_rs1];
      o_rs2_reg = regs[i_rs2];
      if (byp && i_rs1 == i_wa) o_rs1_reg = i_wd;
      if (byp && i_rs2 == i_wa) o_rs2_reg = i_wd;
   end
endmodule

// File: rtl/nnrv_wb.sv
// Writeback stage: commits retiring results to the register file, forwards
// the last committed write to exec, and counts retired instructions.
import nnrv_pkg::*;

module nnrv_wb #(
   parameter int XLEN = XLEN_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_mem_valid,
   input  logic                  i_mem_rd_en,
   input  logic [REG_ADDR_W-1:0] i_mem_rd,
   input  logic [XLEN-1:0]       i_mem_rd_reg,
   input  logic [REG_ADDR_W-1:0] i_dec_rs1,
   input  logic [REG_ADDR_W-1:0] i_dec_rs2,
   output logic [XLEN-1:0]       o_dec_rs1_reg,
   output logic [XLEN-1:0]       o_dec_rs2_reg,
   output logic                  o_wb_rd_en,
   output logic [REG_ADDR_W-1:0] o_wb_rd,
   output logic [XLEN-1:0]       o_wb_rd_reg,
   output logic [CNT_W-1:0]      o_instret
);
   logic             commit;
   logic [CNT_W-1:0] instret_q;

   assign commit = commit_en(i_mem_valid, i_mem_rd_en, i_mem_rd);

   nnrv_regfile #(.XLEN(XLEN)) u_regfile (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_we      (commit),
      .i_wa      (i_mem_rd),
      .i_wd      (i_mem_rd_reg),
      .i_rs1     (i_dec_rs1),
      .i_rs2     (i_dec_rs2),
      .o_rs1_reg (o_dec_rs1_reg),
      .o_rs2_reg (o_dec_rs2_reg)
   );

   // Forward registers track the inputs every cycle; only the enable is qualified.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_wb_rd_en  <= 1'b0;
         o_wb_rd     <= '0;
         o_wb_rd_reg <= '0;
      end else begin
         o_wb_rd_en  <= commit;
         o_wb_rd     <= i_mem_rd;
         o_wb_rd_reg <= i_mem_rd_reg;
      end
   end

   // Free-running retirement count; wraps silently at 2^64.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         instret_q <= '0;
      else if (i_mem_valid)
         instret_q <= instret_q + CNT_W'(1);
   end

   assign o_instret = instret_q;
endmodule

// File: tb/tb_nnrv_wb.sv
// Random plus directed bench for nnrv_wb against an array-based register model.
`timescale 1ns/1ps
module tb_nnrv_wb;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid, rd_en;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] wdata;
   logic [31:0] rs1_reg, rs2_reg;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_reg;
   logic [63:0] instret;

   always #5 clk = ~clk;

   nnrv_wb #(.XLEN(32)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_mem_valid(valid), .i_mem_rd_en(rd_en), .i_mem_rd(rd), .i_mem_rd_reg(wdata),
      .i_dec_rs1(rs1), .i_dec_rs2(rs2),
      .o_dec_rs1_reg(rs1_reg), .o_dec_rs2_reg(rs2_reg),
      .o_wb_rd_en(wb_en), .o_wb_rd(wb_rd), .o_wb_rd_reg(wb_reg),
      .o_instret(instret)
   );

   // reference state
   logic [31:0] m_regs [32];
   longint unsigned m_cnt;
   logic        m_wb_en;
   logic [4:0]  m_wb_rd;
   logic [31:0] m_wb_reg;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] idx);
      if (idx == 0) return 32'h0;
      if (rst_n && valid && rd_en && rd != 0 && rd == idx) return wdata;
      return m_regs[idx];
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_cnt = 0; m_wb_en = 0; m_wb_rd = 0; m_wb_reg = 0;
   endtask

   task automatic check_outs(input string tag);
      check({tag, ".wb_en"}, 64'(wb_en), 64'(m_wb_en));
      check({tag, ".wb_rd"}, 64'(wb_rd), 64'(m_wb_rd));
      check({tag, ".wb_reg"}, 64'(wb_reg), 64'(m_wb_reg));
      check({tag, ".instret"}, instret, m_cnt);
   endtask

   // one retirement slot: drive at negedge, check reads, clock, check registered outputs
   task automatic cycle(input string tag, input logic v, input logic e, input logic [4:0] d,
                        input logic [31:0] w, input logic [4:0] a, input logic [4:0] b);
      @(negedge clk);
      valid = v; rd_en = e; rd = d; wdata = w; rs1 = a; rs2 = b;
      #2;
      check({tag, ".rs1"}, 64'(rs1_reg), 64'(m_read(a)));
      check({tag, ".rs2"}, 64'(rs2_reg), 64'(m_read(b)));
      @(posedge clk);
      if (rst_n) begin
         if (v) m_cnt = m_cnt + 1;
         m_wb_en  = v && e && d != 0;
         m_wb_rd  = d;
         m_wb_reg = w;
         if (m_wb_en) m_regs[d] = w;
      end
      #1;
      check_outs(tag);
   endtask

   initial begin
      logic [4:0] r;
      rst_n = 0; valid = 0; rd_en = 0; rd = 0; wdata = 0; rs1 = 0; rs2 = 0;
      m_clear();
      #3;
      check("rst.instret", instret, 64'h0);
      check("rst.wb_en", 64'(wb_en), 64'h0);
      rs1 = 5'd4;
      #1;
      check("rst.rs1", 64'(rs1_reg), 64'h0);
      @(negedge clk); rst_n = 1;

      // x5 write then read next cycle, forward visible one cycle after
      cycle("w5", 1, 1, 5, 32'hDEADBEEF, 0, 0);
      check("w5.fwd_en", 64'(wb_en), 64'h1);
      check("w5.fwd_rd", 64'(wb_rd), 64'h5);
      cycle("r5", 0, 0, 0, 0, 5, 5);
      check("r5.val", 64'(rs1_reg), 64'hDEADBEEF);
      // simultaneous bypass on both ports
      cycle("byp7", 1, 1, 7, 32'h12345678, 7, 7);
      // x0 write: no storage, no forward, but counted
      cycle("w0", 1, 1, 0, 32'hFFFFFFFF, 0, 0);
      check("w0.fwd_en", 64'(wb_en), 64'h0);
      // invalid retire ignored
      cycle("inv3", 0, 1, 3, 32'hAA, 3, 0);
      cycle("r3", 0, 0, 0, 0, 3, 7);
      // back-to-back writes to same rd keep the later one
      cycle("bb1", 1, 1, 9, 32'h1111, 9, 0);
      cycle("bb2", 1, 1, 9, 32'h2222, 9, 0);
      cycle("bb3", 0, 0, 0, 0, 9, 9);

      // random traffic with a narrow rd range to provoke hazards
      for (int i = 0; i < 400; i++) begin
         r = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 1) == 1) r = 5'($urandom_range(0, 7));
         cycle("rnd", 1'($urandom), 1'($urandom), r, $urandom,
               ($urandom_range(0, 2) == 0) ? r : 5'($urandom),
               ($urandom_range(0, 2) == 0) ? r : 5'($urandom_range(0, 7)));
      end

      // counter wrap
      @(negedge clk); valid = 0;
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1 release dut.instret_q;
      m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
      #1 check("wrap.pre", instret, 64'hFFFF_FFFF_FFFF_FFFF);
      cycle("wrap", 1, 0, 0, 0, 0, 0);
      check("wrap.zero", instret, 64'h0);

      // asynchronous reset mid-cycle after writing x9
      cycle("w9", 1, 1, 9, 32'h55, 9, 0);
      #2;
      rst_n = 0;
      valid = 1; rd_en = 1; rd = 9; wdata = 32'h77; rs1 = 9; rs2 = 9;
      m_clear();
      #1;
      check("arst.rs1", 64'(rs1_reg), 64'h0);
      check("arst.rs2", 64'(rs2_reg), 64'h0);
      check_outs("arst");
      @(posedge clk); #1;
      check_outs("arst.edge");
      @(negedge clk); rst_n = 1; valid = 0;
      cycle("post.r9", 0, 0, 0, 0, 9, 5);
      cycle("post.w", 1, 1, 12, 32'hCAFEF00D, 12, 0);
      cycle("post.r", 0, 0, 0, 0, 12, 12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, bound 200000 ns");
      $fatal(1, "timeout");
   end
endmodule
